// File: rtl/bomb_controller_if.sv
// Player-side bundle for the bomb controller: movement/button inputs and
// bomb/explosion outputs consumed by the renderer and tile blocks.
interface bomb_controller_if;
    logic       frame_tick;
    logic       place_btn;
    logic [9:0] b_x;
    logic [9:0] b_y;
    logic       bomb_active;
    logic [9:0] bomb_x;
    logic [9:0] bomb_y;
    logic       explosion_active;
    logic [9:0] e_x;
    logic [9:0] e_y;
    logic       explosion_SCEN;
    logic       player_hit;
    logic       ready;

    modport master (
        output frame_tick, place_btn, b_x, b_y,
        input  bomb_active, bomb_x, bomb_y, explosion_active, e_x, e_y,
               explosion_SCEN, player_hit, ready
    );

    modport slave (
        input  frame_tick, place_btn, b_x, b_y,
        output bomb_active, bomb_x, bomb_y, explosion_active, e_x, e_y,
               explosion_SCEN, player_hit, ready
    );
endinterface

// File: rtl/bomb_controller.sv
// Single-bomb sequencer: place -> fuse -> explosion -> cooldown, driven by
// frame ticks, with a registered player-in-blast flag.
module bomb_controller #(
    parameter int unsigned FUSE_FRAMES     = 180,
    parameter int unsigned EXPLODE_FRAMES  = 30,
    parameter int unsigned COOLDOWN_FRAMES = 20,
    parameter int unsigned TILE            = 16,
    parameter int unsigned RANGE           = 48
) (
    input  logic clk,
    input  logic reset,
    bomb_controller_if.slave bc
);
    localparam int unsigned MAX_A  = (FUSE_FRAMES > EXPLODE_FRAMES) ? FUSE_FRAMES : EXPLODE_FRAMES;
    localparam int unsigned MAX_F  = (MAX_A > COOLDOWN_FRAMES) ? MAX_A : COOLDOWN_FRAMES;
    localparam int unsigned CNT_W  = $clog2(MAX_F + 1);

    typedef logic [CNT_W-1:0] cnt_t;
    typedef enum logic [1:0] {IDLE, ARMED, EXPLODE, COOLDOWN} state_t;

    localparam logic [9:0]  HALF10 = 10'(TILE / 2);
    localparam logic [9:0]  MASK10 = ~10'(TILE - 1);
    localparam logic [10:0] T1     = 11'(TILE - 1);
    localparam logic [10:0] TR     = 11'(TILE - 1 + RANGE);

    state_t     state_q;
    cnt_t       cnt_q;
    logic       place_q;
    logic       bomb_active_q, explosion_active_q, scen_q, player_hit_q, ready_q;
    logic [9:0] bomb_x_q, bomb_y_q, e_x_q, e_y_q;

    logic       place_rise;
    logic       last_tick;
    logic [9:0] snap_x, snap_y;
    logic [10:0] bx, by, ex, ey;
    logic       h_arm, v_arm, hit_d;

    always_comb begin
        place_rise = bc.place_btn & ~place_q;
        last_tick  = bc.frame_tick && (cnt_q == cnt_t'(1));
        // 10-bit wraparound keeps exactly the low bits of the 11-bit sum
        snap_x = (bc.b_x + HALF10) & MASK10;
        snap_y = (bc.b_y + HALF10) & MASK10;
        bx = {1'b0, bc.b_x};
        by = {1'b0, bc.b_y};
        ex = {1'b0, e_x_q};
        ey = {1'b0, e_y_q};
        h_arm = (bx + TR >= ex) && (bx <= ex + TR) && (by + T1 >= ey) && (by <= ey + T1);
        v_arm = (by + TR >= ey) && (by <= ey + TR) && (bx + T1 >= ex) && (bx <= ex + T1);
        hit_d = explosion_active_q & (h_arm | v_arm);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q            <= IDLE;
            cnt_q              <= '0;
            place_q            <= 1'b1;
            bomb_active_q      <= 1'b0;
            explosion_active_q <= 1'b0;
            scen_q             <= 1'b0;
            player_hit_q       <= 1'b0;
            ready_q            <= 1'b1;
            bomb_x_q           <= '0;
            bomb_y_q           <= '0;
            e_x_q              <= '0;
            e_y_q              <= '0;
        end else begin
            place_q      <= bc.place_btn;
            scen_q       <= 1'b0;
            player_hit_q <= hit_d;
            case (state_q)
                IDLE: begin
                    if (place_rise) begin
                        bomb_x_q      <= snap_x;
                        bomb_y_q      <= snap_y;
                        cnt_q         <= cnt_t'(FUSE_FRAMES);
                        bomb_active_q <= 1'b1;
                        ready_q       <= 1'b0;
                        state_q       <= ARMED;
                    end
                end
                ARMED: begin
                    if (last_tick) begin
                        e_x_q              <= bomb_x_q;
                        e_y_q              <= bomb_y_q;
                        scen_q             <= 1'b1;
                        bomb_active_q      <= 1'b0;
                        explosion_active_q <= 1'b1;
                        cnt_q              <= cnt_t'(EXPLODE_FRAMES);
                        state_q            <= EXPLODE;
                    end else if (bc.frame_tick) begin
                        cnt_q <= cnt_q - cnt_t'(1);
                    end
                end
                EXPLODE: begin
                    if (last_tick) begin
                        explosion_active_q <= 1'b0;
                        cnt_q              <= cnt_t'(COOLDOWN_FRAMES);
                        state_q            <= COOLDOWN;
                    end else if (bc.frame_tick) begin
                        cnt_q <= cnt_q - cnt_t'(1);
                    end
                end
                COOLDOWN: begin
                    if (last_tick) begin
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end else if (bc.frame_tick) begin
                        cnt_q <= cnt_q - cnt_t'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bc.bomb_active      = bomb_active_q;
    assign bc.bomb_x           = bomb_x_q;
    assign bc.bomb_y           = bomb_y_q;
    assign bc.explosion_active = explosion_active_q;
    assign bc.e_x              = e_x_q;
    assign bc.e_y              = e_y_q;
    assign bc.explosion_SCEN   = scen_q;
    assign bc.player_hit       = player_hit_q;
    assign bc.ready            = ready_q;
endmodule

// File: tb/tb_bomb_controller.sv
// Directed bench for bomb_controller with FUSE=3, EXPLODE=2, COOLDOWN=1.
module tb_bomb_controller;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad = 0;
    int   scen_cnt = 0;

    always #5 clk = ~clk;

    bomb_controller_if bc_if ();

    bomb_controller #(
        .FUSE_FRAMES(3),
        .EXPLODE_FRAMES(2),
        .COOLDOWN_FRAMES(1),
        .TILE(16),
        .RANGE(48)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bc(bc_if)
    );

    always @(negedge clk) if (bc_if.explosion_SCEN === 1'b1) scen_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick();
        bc_if.frame_tick = 1'b1;
        step();
        bc_if.frame_tick = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bc_if.frame_tick = 1'b0;
        bc_if.place_btn  = 1'b1;
        bc_if.b_x = 10'd167;
        bc_if.b_y = 10'd50;
        step(3);
        chk("rst_ready", 32'(bc_if.ready), 1);
        chk("rst_bomb_active", 32'(bc_if.bomb_active), 0);
        chk("rst_expl_active", 32'(bc_if.explosion_active), 0);
        chk("rst_scen", 32'(bc_if.explosion_SCEN), 0);
        chk("rst_hit", 32'(bc_if.player_hit), 0);
        chk("rst_bomb_x", 32'(bc_if.bomb_x), 0);
        chk("rst_e_y", 32'(bc_if.e_y), 0);

        // button held through reset release must not place
        reset = 1'b0;
        step(3);
        chk("held_rel_ready", 32'(bc_if.ready), 1);
        chk("held_rel_bomb", 32'(bc_if.bomb_active), 0);

        // arm with a coincident tick that must not count
        bc_if.place_btn = 1'b0;
        step();
        bc_if.place_btn = 1'b1;
        bc_if.frame_tick = 1'b1;
        step();
        bc_if.frame_tick = 1'b0;
        bc_if.place_btn = 1'b0;
        chk("arm_bomb_active", 32'(bc_if.bomb_active), 1);
        chk("arm_bomb_x", 32'(bc_if.bomb_x), 160);
        chk("arm_bomb_y", 32'(bc_if.bomb_y), 48);
        chk("arm_ready", 32'(bc_if.ready), 0);

        bc_if.b_x = 10'd0;
        bc_if.b_y = 10'd0;
        bc_if.place_btn = 1'b1;
        step();
        bc_if.place_btn = 1'b0;
        step();
        chk("armed_ignore_x", 32'(bc_if.bomb_x), 160);
        chk("armed_ignore_y", 32'(bc_if.bomb_y), 48);

        tick();
        step();
        tick();
        chk("fuse2_scen", 32'(bc_if.explosion_SCEN), 0);
        chk("fuse2_bomb", 32'(bc_if.bomb_active), 1);
        bc_if.b_x = 10'd208;
        bc_if.b_y = 10'd48;
        tick();
        chk("det_scen", 32'(bc_if.explosion_SCEN), 1);
        chk("det_e_x", 32'(bc_if.e_x), 160);
        chk("det_e_y", 32'(bc_if.e_y), 48);
        chk("det_expl_active", 32'(bc_if.explosion_active), 1);
        chk("det_bomb_active", 32'(bc_if.bomb_active), 0);
        chk("det_hit_latency", 32'(bc_if.player_hit), 0);
        step();
        chk("scen_one_cycle", 32'(bc_if.explosion_SCEN), 0);
        chk("hit_208_48", 32'(bc_if.player_hit), 1);

        bc_if.b_x = 10'd232;
        step();
        chk("hit_232_48", 32'(bc_if.player_hit), 0);
        bc_if.b_x = 10'd176;
        bc_if.b_y = 10'd64;
        step();
        chk("hit_diag", 32'(bc_if.player_hit), 0);
        bc_if.b_x = 10'd160;
        bc_if.b_y = 10'd0;
        bc_if.place_btn = 1'b1;
        step();
        chk("hit_160_0", 32'(bc_if.player_hit), 1);
        bc_if.place_btn = 1'b0;
        step();
        chk("expl_ignore_x", 32'(bc_if.bomb_x), 160);

        tick();
        chk("expl_still", 32'(bc_if.explosion_active), 1);
        tick();
        chk("cool_expl_off", 32'(bc_if.explosion_active), 0);
        chk("cool_e_x_kept", 32'(bc_if.e_x), 160);
        chk("cool_ready", 32'(bc_if.ready), 0);
        step();
        chk("cool_hit_off", 32'(bc_if.player_hit), 0);

        // press during cooldown and keep holding across return to idle
        bc_if.place_btn = 1'b1;
        step();
        tick();
        chk("idle_ready", 32'(bc_if.ready), 1);
        step(2);
        chk("held_idle_bomb", 32'(bc_if.bomb_active), 0);
        chk("held_idle_ready", 32'(bc_if.ready), 1);

        bc_if.place_btn = 1'b0;
        bc_if.b_x = 10'd0;
        bc_if.b_y = 10'd0;
        step();
        bc_if.place_btn = 1'b1;
        step();
        bc_if.place_btn = 1'b0;
        chk("origin_bomb", 32'(bc_if.bomb_active), 1);
        chk("origin_x", 32'(bc_if.bomb_x), 0);
        chk("origin_y", 32'(bc_if.bomb_y), 0);
        tick();
        step();
        tick();
        step();
        tick();
        chk("origin_scen", 32'(bc_if.explosion_SCEN), 1);
        chk("origin_e_x", 32'(bc_if.e_x), 0);
        step();
        chk("origin_hit", 32'(bc_if.player_hit), 1);
        tick();
        tick();
        tick();
        chk("origin_back_idle", 32'(bc_if.ready), 1);

        // reset while the final fuse tick is pending
        step();
        bc_if.place_btn = 1'b1;
        step();
        bc_if.place_btn = 1'b0;
        tick();
        tick();
        chk("pre_rst_armed", 32'(bc_if.bomb_active), 1);
        bc_if.frame_tick = 1'b1;
        bc_if.place_btn = 1'b1;
        reset = 1'b1;
        #1;
        chk("midrst_ready", 32'(bc_if.ready), 1);
        chk("midrst_bomb", 32'(bc_if.bomb_active), 0);
        chk("midrst_bomb_x", 32'(bc_if.bomb_x), 0);
        step(2);
        bc_if.frame_tick = 1'b0;
        chk("midrst_scen", 32'(bc_if.explosion_SCEN), 0);
        reset = 1'b0;
        step(3);
        chk("rel_held_ready", 32'(bc_if.ready), 1);
        chk("rel_held_bomb", 32'(bc_if.bomb_active), 0);
        chk("scen_pulse_count", 32'(scen_cnt), 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bomb_controller.md
Name: bomb_controller

Overview:
- Single-bomb sequencer for the player.
- Latches a grid-snapped bomb position on a place request, then runs the fuse on frame ticks.
- When the fuse expires it issues the one-cycle explosion_SCEN and explosion coordinates consumed by the box/wall tile blocks, holds the explosion visible, then enforces a cooldown.
- Also flags when the player is inside the explosion plus-shape.

Parameters:
- FUSE_FRAMES, 180, frame ticks from arming to detonation (>=1)
- EXPLODE_FRAMES, 30, frame ticks the explosion stays active (>=1)
- COOLDOWN_FRAMES, 20, frame ticks after the explosion before a new bomb is accepted (>=1)
- TILE, 16, tile size in pixels (power of two); also bomberman sprite size
- RANGE, 48, explosion arm length in pixels beyond the centre tile

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- frame_tick  in  1  one-clk pulse per video frame
- place_btn  in  1  debounced place-bomb level
- b_x  in  10  bomberman top-left x
- b_y  in  10  bomberman top-left y
- bomb_active  out  1  bomb sprite visible (fuse running)
- bomb_x  out  10  bomb tile top-left x
- bomb_y  out  10  bomb tile top-left y
- explosion_active  out  1  explosion sprite visible
- e_x  out  10  explosion centre tile x
- e_y  out  10  explosion centre tile y
- explosion_SCEN  out  1  one-clk pulse at detonation
- player_hit  out  1  bomberman overlaps the active explosion
- ready  out  1  controller is in IDLE

Behaviour:
- Clock and reset: clk rising edge; reset asynchronous, active-high. All outputs registered.
- Reset values: state=IDLE; all counters 0; bomb_active, explosion_active, explosion_SCEN and player_hit 0; bomb_x, bomb_y, e_x, e_y 0; ready 1.
- Place-edge register: place_d resets to 1, so a button held through reset release does not place a bomb.
- Place edge: place_rise = place_btn & ~place_d; place_d <= place_btn every cycle.
- Snap rule: bomb_x = ((b_x + TILE/2) computed in 11 bits) with the low log2(TILE) bits cleared, truncated to 10 bits. bomb_y is computed the same way from b_y. Example: b_x=167 -> 175 -> 160.
- IDLE: ready=1.
  - On place_rise: latch bomb_x/bomb_y, load cnt=FUSE_FRAMES, go to ARMED.
  - bomb_active=1 from the next cycle.
- ARMED: bomb_active=1; place_rise is ignored and not queued.
  - On frame_tick with cnt>1: cnt-1.
  - On frame_tick with cnt==1: go to EXPLODE; e_x/e_y <= bomb_x/bomb_y; explosion_SCEN=1 for exactly that one cycle; bomb_active=0; explosion_active=1; load cnt=EXPLODE_FRAMES.
  - A frame_tick in the same cycle as arming is not counted.
- Detonation timing: explosion_SCEN rises on the clk edge after the FUSE_FRAMES-th counted tick.
- EXPLODE: explosion_active=1; e_x/e_y held stable.
  - On frame_tick with cnt==1: explosion_active=0, load cnt=COOLDOWN_FRAMES, go to COOLDOWN.
  - Otherwise decrement cnt on each frame_tick.
- COOLDOWN: all visibility outputs 0; place_rise is ignored.
  - On frame_tick with cnt==1: go to IDLE.
  - A button still held on entry to IDLE does not place; a fresh rising edge is required.
- player_hit: registered, 1-cycle latency. Asserted only while explosion_active. All arithmetic is 11-bit unsigned, with no subtraction, so there is no underflow.
  - H-arm condition: b_x+TILE-1+RANGE >= e_x AND b_x <= e_x+RANGE+TILE-1 AND b_y+TILE-1 >= e_y AND b_y <= e_y+TILE-1.
  - V-arm condition: the same with the x and y roles swapped.
  - hit = H-arm OR V-arm.
- e_x/e_y persistence: retain the last values after EXPLODE; downstream blocks gate on explosion_SCEN/explosion_active.
- Reset mid-operation: immediate return to IDLE, all outputs take their reset values, and no explosion_SCEN is emitted.

Test Plan:
- Common setup for all scenarios: FUSE=3, EXPLODE=2, COOLDOWN=1, TILE=16, RANGE=48.
- Placement and snap: b_x=167, b_y=50, then pulse place_btn -> next cycle bomb_active=1, bomb_x=160, bomb_y=48, ready=0.
- Fuse timing: after arming, 3 frame_ticks -> explosion_SCEN high for exactly 1 clk, on the edge after the 3rd tick. In that same cycle e_x=160, e_y=48, explosion_active=1, bomb_active=0.
- Ignored requests: place_btn edges during ARMED, EXPLODE and COOLDOWN -> no re-latch of bomb_x, and no second bomb after returning to IDLE. With place_btn held across the return to IDLE -> stays IDLE until release followed by a new press.
- Hit detection, bomb at (160,48):
  - b=(208,48) -> player_hit=1 one cycle after explosion_active.
  - b=(232,48) -> player_hit=0.
  - b=(176,64) -> player_hit=0 (diagonal).
  - b=(160,0) -> player_hit=1.
- Reset and edge cases:
  - Assert reset during ARMED with cnt=1 and a tick pending -> all outputs 0, no explosion_SCEN ever emitted, ready=1.
  - Release reset with place_btn=1 -> no placement.
  - Bomb at b_x=0, b_y=0 -> no underflow; player_hit=1 when the player is on the bomb.
